uart_echo_buffer: RTL and testbench
===================================

Name: uart_echo_buffer

Overview:
Buffered, mode-selectable echo engine between the osdvu uart core's receive and transmit ports. It replaces the unbuffered single-register echo: received bytes enter a parametrised FIFO and drain through a transmit handshake state machine. Optional upper-case conversion and line mode (hold until CR, then emit line plus LF) are selectable at run time. It also keeps saturating counters for receive errors and FIFO overflows.

Parameters:
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries of 8 bits
CNT_W, 8, width of err_count and ovf_count (saturating)
LF_CHAR, 8'h0A, byte appended after CR in line mode
CR_CHAR, 8'h0D, line terminator

Ports:
clk  in  1  master clock, same clock as the uart core
rst_n  in  1  reset, asynchronous assert, active-low
mode  in  2  bit0 = upper-case conversion, bit1 = line mode
received  in  1  one-cycle pulse from the uart core; rx_byte is valid
rx_byte  in  8  received byte
recv_error  in  1  one-cycle pulse from the uart core on a framing error
is_transmitting  in  1  uart core transmitter busy
transmit  out  1  one-cycle request to the uart core
tx_byte  out  8  byte to send; stable from the transmit pulse until is_transmitting falls
fifo_count  out  FIFO_AW+1  bytes currently stored
err_count  out  CNT_W  saturating count of recv_error pulses
ovf_count  out  CNT_W  saturating count of bytes dropped because the FIFO was full
busy  out  1  high when the FIFO is non-empty or the TX FSM is not in IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - transmit=0, tx_byte=0, all pointers and counts = 0, FSM = IDLE, active mode = 0.
  - Reset mid-transmission abandons the byte. The uart core finishes it independently.
- Mode latching:
  - The mode input is copied to active_mode only in cycles where busy=0.
  - Changes while busy are ignored until the block goes idle.
- Write path:
  - On received=1 with fifo_count < depth: write the byte. If active_mode[0]=1 and the byte is in 0x61..0x7A, subtract 0x20 before the write. No other byte is altered.
  - On received=1 with fifo_count = depth: drop the byte and increment ovf_count, saturating at all-ones. This applies even if a pop occurs in the same cycle.
  - recv_error=1 increments err_count (saturating). Nothing is written.
  - Simultaneous push and pop with fifo_count neither 0 nor full: both occur and fifo_count is unchanged.
  - Pointers wrap modulo depth. fifo_count is the pointer difference, with the extra bit distinguishing full from empty.
- Release (commit) pointer:
  - Line mode off: the commit pointer tracks the write pointer every cycle.
  - Line mode on: the commit pointer advances to the write pointer only in the cycle after CR_CHAR is written, or when fifo_count reaches depth (forced flush).
  - Readable bytes = commit pointer minus read pointer.
  - Leaving line mode requires idle, so no uncommitted data remains.
- TX FSM states: IDLE, LOAD, REQ, WAIT_BUSY, WAIT_DONE, SEND_LF.
  - IDLE -> LOAD when readable bytes > 0.
  - LOAD: tx_byte <= fifo[rd_ptr]; rd_ptr++; -> REQ.
  - REQ: transmit=1 for exactly one cycle; -> WAIT_BUSY.
  - WAIT_BUSY: wait for is_transmitting=1; -> WAIT_DONE.
  - WAIT_DONE: wait for is_transmitting=0. Then, if line mode and tx_byte==CR_CHAR -> SEND_LF; else -> IDLE.
  - SEND_LF: tx_byte <= LF_CHAR; -> REQ, then WAIT_BUSY, then WAIT_DONE. The LF itself never triggers another LF.
  - transmit is 0 in every state except REQ.
- Latency: received pulse at cycle N gives transmit=1 at cycle N+3, when the FSM is idle and line mode is off.

Test Plan:
- Reset, mode=0, send 0x41 -> transmit pulses 3 cycles later with tx_byte=0x41; busy returns to 0 after the is_transmitting fall.
- mode=01, send 0x61, 0x7A, 0x7B, 0x31 -> transmitted 0x41, 0x5A, 0x7B, 0x31 in order.
- mode=10, send 0x68, 0x69 -> no transmit; fifo_count=2. Send 0x0D -> transmitted 0x68, 0x69, 0x0D, 0x0A.
- FIFO_AW=2, model holds is_transmitting=1 indefinitely, send 6 bytes -> fifo_count saturates at 4, ovf_count=1, the first byte is in flight, and the sixth byte is dropped. Release the model -> remaining bytes 2..5 are sent in order.
- Line mode, FIFO_AW=2, send 4 bytes without CR -> forced flush sends all 4 with no LF.
- Pulse recv_error 300 times with CNT_W=8 -> err_count=255, no transmit. Assert rst_n=0 during WAIT_DONE -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/uart_echo_buffer_if.sv
// Byte-level handshake between the echo buffer and the uart core.
// The echo buffer uses the master view; the uart core (or its model) uses the slave view.
interface uart_echo_buffer_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;

    modport master (
        input  received,
        input  rx_byte,
        input  recv_error,
        input  is_transmitting,
        output transmit,
        output tx_byte
    );

    modport slave (
        output received,
        output rx_byte,
        output recv_error,
        output is_transmitting,
        input  transmit,
        input  tx_byte
    );
endinterface

// File: rtl/uart_echo_buffer.sv
// Buffered echo engine: received bytes pass through a FIFO, optional upper-casing and
// line-mode hold (release on CR, append LF), then drain through a transmit handshake FSM.
module uart_echo_buffer #(
    parameter int         FIFO_AW = 4,
    parameter int         CNT_W   = 8,
    parameter logic [7:0] LF_CHAR = 8'h0A,
    parameter logic [7:0] CR_CHAR = 8'h0D
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    uart_echo_buffer_if.master uart,
    output logic [FIFO_AW:0]   fifo_count,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   ovf_count,
    output logic               busy
);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        WAIT_BUSY,
        WAIT_DONE,
        SEND_LF
    } tx_state_t;

    tx_state_t        state;
    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [FIFO_AW:0] cm_ptr;
    logic [FIFO_AW:0] readable;
    logic [FIFO_AW:0] wr_ptr_next;
    logic [1:0]       active_mode;
    logic             cr_pending;
    logic             full;
    logic             push;
    logic [7:0]       wr_data;

    assign fifo_count  = wr_ptr - rd_ptr;
    assign readable    = cm_ptr - rd_ptr;
    assign full        = (fifo_count == FULL_COUNT);
    assign push        = uart.received && !full;
    assign wr_ptr_next = push ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign busy        = (fifo_count != '0) || (state != IDLE);

    always_comb begin
        wr_data = uart.rx_byte;
        if (active_mode[0] && (uart.rx_byte >= 8'h61) && (uart.rx_byte <= 8'h7A)) begin
            wr_data = uart.rx_byte - 8'h20;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= wr_data;
        end
    end

    // Write side: pointers, line-mode commit and the saturating error counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            cm_ptr      <= '0;
            cr_pending  <= 1'b0;
            active_mode <= '0;
            err_count   <= '0;
            ovf_count   <= '0;
        end else begin
            if (!busy) begin
                active_mode <= mode;
            end
            wr_ptr     <= wr_ptr_next;
            cr_pending <= push && (wr_data == CR_CHAR);
            if (!active_mode[1]) begin
                cm_ptr <= wr_ptr_next;
            end else if (cr_pending || full) begin
                cm_ptr <= wr_ptr;
            end
            if (uart.recv_error && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_ONE;
            end
            if (uart.received && full && (ovf_count != CNT_MAX)) begin
                ovf_count <= ovf_count + CNT_ONE;
            end
        end
    end

    // Transmit side: tx_byte is held from the request until the core drops is_transmitting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            uart.tx_byte  <= '0;
            uart.transmit <= 1'b0;
        end else begin
            uart.transmit <= 1'b0;
            case (state)
                IDLE: begin
                    if (readable != '0) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    uart.tx_byte  <= mem[rd_ptr[FIFO_AW-1:0]];
                    rd_ptr        <= rd_ptr + PTR_ONE;
                    uart.transmit <= 1'b1;
                    state         <= REQ;
                end
                REQ: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (uart.is_transmitting) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart.is_transmitting) begin
                        if (active_mode[1] && (uart.tx_byte == CR_CHAR)) begin
                            state <= SEND_LF;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                SEND_LF: begin
                    uart.tx_byte  <= LF_CHAR;
                    uart.transmit <= 1'b1;
                    state         <= REQ;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench for uart_echo_buffer with a small uart transmitter model that can be
// held busy; every transmitted byte is logged and compared against hand-computed values.
module tb_uart_echo_buffer;

    logic       clk;
    logic       rst_n;
    logic [1:0] mode;
    logic [2:0] fifo_count;
    logic [7:0] err_count;
    logic [7:0] ovf_count;
    logic       busy;
    logic       hold_tx;
    logic [7:0] tx_log[$];
    int         checks_total;
    int         checks_passed;

    uart_echo_buffer_if uif ();

    uart_echo_buffer #(
        .FIFO_AW(2),
        .CNT_W  (8),
        .LF_CHAR(8'h0A),
        .CR_CHAR(8'h0D)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .uart      (uif),
        .fifo_count(fifo_count),
        .err_count (err_count),
        .ovf_count (ovf_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Uart transmitter model: goes busy the cycle after a request, stays busy 4 cycles
    // or for as long as hold_tx is set.
    initial begin
        uif.is_transmitting = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (uif.transmit === 1'b1) begin
                tx_log.push_back(uif.tx_byte);
                @(posedge clk);
                #1;
                uif.is_transmitting = 1'b1;
                repeat (4) @(posedge clk);
                while (hold_tx) @(posedge clk);
                #1;
                uif.is_transmitting = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        assert (observed === expected) begin
            checks_passed++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        uif.received = 1'b1;
        uif.rx_byte  = b;
        tick();
        uif.received = 1'b0;
        uif.rx_byte  = 8'h00;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        tick();
        tick();
    endtask

    task automatic wait_tx_count(input string tag, input int n);
        for (int i = 0; i < 500 && tx_log.size() < n; i++) tick();
        check_output(tag, 32'(tx_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (busy || uif.is_transmitting); i++) tick();
        tick();
        check_output(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [7:0] expected);
        if (idx < tx_log.size()) check_output(tag, 32'(tx_log[idx]), 32'(expected));
        else check_output(tag, 32'hFFFF_FFFF, 32'(expected));
    endtask

    initial begin
        checks_total      = 0;
        checks_passed     = 0;
        hold_tx           = 1'b0;
        rst_n             = 1'b0;
        mode              = 2'b00;
        uif.received      = 1'b0;
        uif.rx_byte       = 8'h00;
        uif.recv_error    = 1'b0;
        tick();
        tick();
        check_output("reset_transmit", 32'(uif.transmit), 32'd0);
        check_output("reset_tx_byte", 32'(uif.tx_byte), 32'd0);
        check_output("reset_fifo_count", 32'(fifo_count), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Plain echo and its three-cycle latency
        apply_stimulus(8'h41);
        check_output("lat_n1_transmit", 32'(uif.transmit), 32'd0);
        check_output("lat_n1_busy", 32'(busy), 32'd1);
        tick();
        check_output("lat_n2_transmit", 32'(uif.transmit), 32'd0);
        tick();
        check_output("lat_n3_transmit", 32'(uif.transmit), 32'd1);
        check_output("lat_n3_tx_byte", 32'(uif.tx_byte), 32'h41);
        tick();
        check_output("lat_pulse_width", 32'(uif.transmit), 32'd0);
        wait_idle("echo_idle");
        check_log("echo_byte", 0, 8'h41);
        tx_log.delete();

        // Upper-case conversion
        set_mode(2'b01);
        apply_stimulus(8'h61);
        apply_stimulus(8'h7A);
        apply_stimulus(8'h7B);
        apply_stimulus(8'h31);
        wait_tx_count("upper_count", 4);
        check_log("upper_0", 0, 8'h41);
        check_log("upper_1", 1, 8'h5A);
        check_log("upper_2", 2, 8'h7B);
        check_log("upper_3", 3, 8'h31);
        wait_idle("upper_idle");
        tx_log.delete();

        // Overflow while the transmitter is held busy
        set_mode(2'b00);
        hold_tx = 1'b1;
        apply_stimulus(8'h11);
        apply_stimulus(8'h12);
        apply_stimulus(8'h13);
        apply_stimulus(8'h14);
        apply_stimulus(8'h15);
        apply_stimulus(8'h16);
        repeat (4) tick();
        check_output("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check_output("ovf_count", 32'(ovf_count), 32'd1);
        check_output("ovf_in_flight_n", 32'(tx_log.size()), 32'd1);
        check_log("ovf_in_flight", 0, 8'h11);
        hold_tx = 1'b0;
        wait_tx_count("ovf_drain_count", 5);
        check_log("ovf_drain_1", 1, 8'h12);
        check_log("ovf_drain_2", 2, 8'h13);
        check_log("ovf_drain_3", 3, 8'h14);
        check_log("ovf_drain_4", 4, 8'h15);
        wait_idle("ovf_idle");
        check_output("ovf_sixth_dropped", 32'(tx_log.size()), 32'd5);
        tx_log.delete();

        // Line mode: hold until CR, then append LF
        set_mode(2'b10);
        apply_stimulus(8'h68);
        apply_stimulus(8'h69);
        repeat (10) tick();
        check_output("line_held_n", 32'(tx_log.size()), 32'd0);
        check_output("line_held_count", 32'(fifo_count), 32'd2);
        apply_stimulus(8'h0D);
        wait_tx_count("line_count", 4);
        check_log("line_0", 0, 8'h68);
        check_log("line_1", 1, 8'h69);
        check_log("line_2", 2, 8'h0D);
        check_log("line_3", 3, 8'h0A);
        wait_idle("line_idle");
        tx_log.delete();

        // Line mode forced flush on a full FIFO, no LF
        apply_stimulus(8'h31);
        apply_stimulus(8'h32);
        apply_stimulus(8'h33);
        apply_stimulus(8'h34);
        wait_tx_count("flush_count", 4);
        check_log("flush_0", 0, 8'h31);
        check_log("flush_1", 1, 8'h32);
        check_log("flush_2", 2, 8'h33);
        check_log("flush_3", 3, 8'h34);
        wait_idle("flush_idle");
        check_output("flush_no_lf", 32'(tx_log.size()), 32'd4);
        tx_log.delete();

        // Saturating receive-error counter
        set_mode(2'b00);
        for (int i = 0; i < 300; i++) begin
            uif.recv_error = 1'b1;
            tick();
            uif.recv_error = 1'b0;
            tick();
        end
        check_output("err_saturated", 32'(err_count), 32'd255);
        check_output("err_no_transmit", 32'(tx_log.size()), 32'd0);
        check_output("err_no_write", 32'(fifo_count), 32'd0);
        check_output("ovf_kept", 32'(ovf_count), 32'd1);

        // Asynchronous reset while waiting for the transmitter to finish
        hold_tx = 1'b1;
        apply_stimulus(8'h55);
        for (int i = 0; i < 100 && !uif.is_transmitting; i++) tick();
        check_output("rst_tx_started", 32'(uif.is_transmitting), 32'd1);
        tick();
        tick();
        check_output("rst_pre_busy", 32'(busy), 32'd1);
        check_output("rst_pre_tx_byte", 32'(uif.tx_byte), 32'h55);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async_transmit", 32'(uif.transmit), 32'd0);
        check_output("rst_async_tx_byte", 32'(uif.tx_byte), 32'd0);
        check_output("rst_async_fifo_count", 32'(fifo_count), 32'd0);
        check_output("rst_async_err_count", 32'(err_count), 32'd0);
        check_output("rst_async_ovf_count", 32'(ovf_count), 32'd0);
        check_output("rst_async_busy", 32'(busy), 32'd0);
        hold_tx = 1'b0;
        repeat (8) tick();
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
